// File: rtl/msix_wr_gen.sv
// msix_wr_gen: MSI-X vector table with pending bits and round-robin single-DW host write issue.
module msix_wr_gen #(
   parameter int NUM_VEC = 4,
   parameter int SENT_W  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cfg_we,
   input  logic [$clog2(NUM_VEC)-1:0] cfg_vec,
   input  logic [63:0]                cfg_addr,
   input  logic [31:0]                cfg_data,
   input  logic                       cfg_mask,
   input  logic                       func_en,
   input  logic [NUM_VEC-1:0]         intr_req,
   output logic                       wr_valid,
   input  logic                       wr_ready,
   output logic [63:0]                wr_addr,
   output logic [31:0]                wr_data,
   output logic [NUM_VEC-1:0]         pend,
   output logic [SENT_W-1:0]          sent_cnt
);
   localparam int VW = $clog2(NUM_VEC);
   typedef enum logic {IDLE, ISSUE} state_t;
   state_t state, state_n;
   logic [63:0] addr_q [NUM_VEC];
   logic [31:0] data_q [NUM_VEC];
   logic [NUM_VEC-1:0] mask_q, elig, clr;
   logic [VW-1:0] ptr, sel, nxt_sel, idx;
   logic found, issue, hs;
   assign elig = pend & ~mask_q;
   // descending scan so the eligible vector closest after ptr wins
   always_comb begin
      nxt_sel = '0;
      idx = '0;
      found = 1'b0;
      for (int k = NUM_VEC - 1; k >= 0; k--) begin
         idx = VW'((32'(ptr) + 32'(k)) % NUM_VEC);
         if (elig[idx]) begin
            nxt_sel = idx;
            found = 1'b1;
         end
      end
   end
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_n;
   always_comb
      state_n = (state == IDLE) ? ((func_en && found) ? ISSUE : IDLE) : (wr_ready ? IDLE : ISSUE);
   always_comb begin
      wr_valid = (state == ISSUE);
      issue = (state == IDLE) && func_en && found;
      hs = wr_valid && wr_ready;
      clr = hs ? (NUM_VEC'(1) << sel) : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_addr <= '0;
         wr_data <= '0;
         sel <= '0;
         ptr <= '0;
         pend <= '0;
         sent_cnt <= '0;
         mask_q <= '1;
         for (int i = 0; i < NUM_VEC; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         if (cfg_we && 32'(cfg_vec) < NUM_VEC) begin
            addr_q[cfg_vec] <= cfg_addr;
            data_q[cfg_vec] <= cfg_data;
            mask_q[cfg_vec] <= cfg_mask;
         end
         // a new request in the accepting cycle survives the clear
         pend <= (pend & ~clr) | intr_req;
         if (issue) begin
            sel <= nxt_sel;
            wr_addr <= addr_q[nxt_sel];
            wr_data <= data_q[nxt_sel];
         end
         if (hs) begin
            ptr <= (sel == VW'(NUM_VEC - 1)) ? '0 : sel + VW'(1);
            if (sent_cnt != '1) sent_cnt <= sent_cnt + SENT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_msix_wr_gen.sv
// tb_msix_wr_gen: scoreboard bench for msix_wr_gen (4 vectors, 3-bit counter to reach saturation).
module tb_msix_wr_gen;
   logic clk = 1'b0;
   logic rst = 1'b1, cfg_we = 1'b0, cfg_mask = 1'b0, func_en = 1'b0, wr_ready = 1'b0;
   logic [1:0] cfg_vec = '0;
   logic [63:0] cfg_addr = '0;
   logic [31:0] cfg_data = '0;
   logic [3:0] intr_req = '0;
   logic wr_valid;
   logic [63:0] wr_addr;
   logic [31:0] wr_data;
   logic [3:0] pend;
   logic [2:0] sent_cnt;
   int n_cmp = 0, n_err = 0, cyc = 0, obs_wr = 0, obs_rd = 0;
   logic [95:0] exp_q [$];
   logic [95:0] obs_ad [512];
   int obs_cy [512];

   msix_wr_gen #(.NUM_VEC(4), .SENT_W(3)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_vec(cfg_vec), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .cfg_mask(cfg_mask), .func_en(func_en), .intr_req(intr_req),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .pend(pend), .sent_cnt(sent_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // host side: every accepted write lands here with the cycle it was accepted in
   always @(negedge clk)
      if (wr_valid && wr_ready && !rst && obs_wr < 512) begin
         obs_ad[obs_wr] <= {wr_addr, wr_data};
         obs_cy[obs_wr] <= cyc;
         obs_wr <= obs_wr + 1;
      end

   task tick();
      @(posedge clk);
      #1;
   endtask

   task run(input int n);
      repeat (n) tick();
   endtask

   task do_reset();
      rst = 1'b1;
      run(2);
      rst = 1'b0;
      exp_q.delete();
      obs_rd = obs_wr;
   endtask

   task cfg(input logic [1:0] v, input logic [63:0] a, input logic [31:0] d, input logic m);
      cfg_we = 1'b1;
      cfg_vec = v;
      cfg_addr = a;
      cfg_data = d;
      cfg_mask = m;
      tick();
      cfg_we = 1'b0;
   endtask

   task test_reset();
      do_reset();
      @(negedge clk);
      n_cmp++; if (wr_valid !== 1'b0) begin n_err++; $display("FAIL reset wr_valid: got %b expected 0", wr_valid); end
      n_cmp++; if (pend !== 4'h0) begin n_err++; $display("FAIL reset pend: got %h expected 0", pend); end
      n_cmp++; if (sent_cnt !== 3'd0) begin n_err++; $display("FAIL reset sent_cnt: got %0d expected 0", sent_cnt); end
      n_cmp++; if ({wr_addr, wr_data} !== 96'h0) begin n_err++; $display("FAIL reset wr_addr/data: got %h expected 0", {wr_addr, wr_data}); end
      tick();
      func_en = 1'b1;
      intr_req = 4'hF;
      tick();
      intr_req = 4'h0;
      run(4);
      @(negedge clk);
      n_cmp++; if (pend !== 4'hF) begin n_err++; $display("FAIL reset masked pend: got %h expected f", pend); end
      n_cmp++; if (wr_valid !== 1'b0 || obs_wr != obs_rd) begin n_err++; $display("FAIL reset masked write: got valid=%b writes=%0d expected 0/0", wr_valid, obs_wr - obs_rd); end
      tick();
      do_reset();
   endtask

   task test_latency();
      logic [95:0] e, o;
      cfg(2'd0, 64'h1, 32'h12345678, 1'b0);
      func_en = 1'b1;
      wr_ready = 1'b1;
      intr_req = 4'b0001;
      exp_q.push_back({64'h1, 32'h12345678});
      tick();
      intr_req = 4'h0;
      @(negedge clk);
      n_cmp++; if (pend !== 4'b0001 || wr_valid !== 1'b0) begin n_err++; $display("FAIL latency N+1: got pend=%h valid=%b expected 1/0", pend, wr_valid); end
      tick();
      @(negedge clk);
      n_cmp++; if (wr_valid !== 1'b1) begin n_err++; $display("FAIL latency N+2 valid: got %b expected 1", wr_valid); end
      tick();
      @(negedge clk);
      n_cmp++; if (wr_valid !== 1'b0 || sent_cnt !== 3'd1 || pend !== 4'h0) begin n_err++; $display("FAIL latency after: got valid=%b cnt=%0d pend=%h expected 0/1/0", wr_valid, sent_cnt, pend); end
      run(2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_cmp++;
         o = (obs_rd < obs_wr) ? obs_ad[obs_rd] : 'x;
         if (obs_rd < obs_wr) obs_rd++;
         if (o !== e) begin n_err++; $display("FAIL latency write: got %h expected %h", o, e); end
      end
      n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL latency extra writes: got %0d expected 0", obs_wr - obs_rd); obs_rd = obs_wr; end
   endtask

   task test_stall();
      logic [95:0] e, o;
      wr_ready = 1'b0;
      intr_req = 4'b0001;
      exp_q.push_back({64'h1, 32'h12345678});
      tick();
      intr_req = 4'h0;
      tick();
      @(negedge clk);
      n_cmp++; if (wr_valid !== 1'b1) begin n_err++; $display("FAIL stall valid: got %b expected 1", wr_valid); end
      tick();
      func_en = 1'b0;
      cfg(2'd0, 64'h1, 32'hDEAD, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++; if (wr_valid !== 1'b1 || wr_data !== 32'h12345678) begin n_err++; $display("FAIL stall hold %0d: got valid=%b data=%h expected 1/12345678", i, wr_valid, wr_data); end
         tick();
      end
      func_en = 1'b1;
      wr_ready = 1'b1;
      tick();
      intr_req = 4'b0001;
      exp_q.push_back({64'h1, 32'h0000DEAD});
      tick();
      intr_req = 4'h0;
      run(4);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_cmp++;
         o = (obs_rd < obs_wr) ? obs_ad[obs_rd] : 'x;
         if (obs_rd < obs_wr) obs_rd++;
         if (o !== e) begin n_err++; $display("FAIL stall write: got %h expected %h", o, e); end
      end
      n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL stall extra writes: got %0d expected 0", obs_wr - obs_rd); obs_rd = obs_wr; end
      n_cmp++; if (sent_cnt !== 3'd3) begin n_err++; $display("FAIL stall sent_cnt: got %0d expected 3", sent_cnt); end
   endtask

   task test_all4();
      logic [95:0] e, o;
      int n0;
      do_reset();
      for (int i = 0; i < 4; i++) cfg(2'(i), 64'h100 + 64'(i), 32'hC0DE0000 + 32'(i), 1'b0);
      func_en = 1'b1;
      wr_ready = 1'b1;
      n0 = cyc;
      intr_req = 4'hF;
      for (int i = 0; i < 4; i++) exp_q.push_back({64'h100 + 64'(i), 32'hC0DE0000 + 32'(i)});
      tick();
      intr_req = 4'h0;
      run(10);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (obs_rd + i >= obs_wr || obs_cy[obs_rd + i] != n0 + 2 + 2 * i) begin
            n_err++; $display("FAIL all4 spacing %0d: got cycle %0d expected %0d", i, (obs_rd + i < obs_wr) ? obs_cy[obs_rd + i] - n0 : -1, 2 + 2 * i);
         end
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_cmp++;
         o = (obs_rd < obs_wr) ? obs_ad[obs_rd] : 'x;
         if (obs_rd < obs_wr) obs_rd++;
         if (o !== e) begin n_err++; $display("FAIL all4 write: got %h expected %h", o, e); end
      end
      n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL all4 extra writes: got %0d expected 0", obs_wr - obs_rd); obs_rd = obs_wr; end
      n_cmp++; if (pend !== 4'h0 || sent_cnt !== 3'd4) begin n_err++; $display("FAIL all4 end: got pend=%h cnt=%0d expected 0/4", pend, sent_cnt); end
   endtask

   task test_mask();
      logic [95:0] e, o;
      cfg(2'd2, 64'h102, 32'hC0DE0002, 1'b1);
      for (int i = 0; i < 3; i++) begin
         intr_req = 4'b0100;
         tick();
         intr_req = 4'h0;
         tick();
      end
      run(3);
      @(negedge clk);
      n_cmp++; if (pend !== 4'b0100) begin n_err++; $display("FAIL mask pend: got %h expected 4", pend); end
      n_cmp++; if (wr_valid !== 1'b0 || obs_wr != obs_rd) begin n_err++; $display("FAIL mask blocked: got valid=%b writes=%0d expected 0/0", wr_valid, obs_wr - obs_rd); end
      tick();
      cfg(2'd2, 64'h102, 32'hC0DE0002, 1'b0);
      exp_q.push_back({64'h102, 32'hC0DE0002});
      run(6);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_cmp++;
         o = (obs_rd < obs_wr) ? obs_ad[obs_rd] : 'x;
         if (obs_rd < obs_wr) obs_rd++;
         if (o !== e) begin n_err++; $display("FAIL mask write: got %h expected %h", o, e); end
      end
      n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL mask extra writes: got %0d expected 0", obs_wr - obs_rd); obs_rd = obs_wr; end
      n_cmp++; if (pend !== 4'h0 || sent_cnt !== 3'd5) begin n_err++; $display("FAIL mask end: got pend=%h cnt=%0d expected 0/5", pend, sent_cnt); end
   endtask

   task test_rst_issue();
      wr_ready = 1'b0;
      intr_req = 4'b0010;
      tick();
      intr_req = 4'h0;
      tick();
      @(negedge clk);
      n_cmp++; if (wr_valid !== 1'b1) begin n_err++; $display("FAIL rst_issue valid: got %b expected 1", wr_valid); end
      tick();
      rst = 1'b1;
      intr_req = 4'b1000;
      cfg_we = 1'b1; cfg_vec = 2'd3; cfg_addr = 64'h300; cfg_data = 32'h3; cfg_mask = 1'b0;
      tick();
      rst = 1'b0;
      intr_req = 4'h0;
      cfg_we = 1'b0;
      @(negedge clk);
      n_cmp++; if (wr_valid !== 1'b0 || pend !== 4'h0 || sent_cnt !== 3'd0) begin n_err++; $display("FAIL rst_issue after: got valid=%b pend=%h cnt=%0d expected 0/0/0", wr_valid, pend, sent_cnt); end
      tick();
      wr_ready = 1'b1;
      run(5);
      n_cmp++; if (obs_wr != obs_rd || pend !== 4'h0) begin n_err++; $display("FAIL rst_issue no write: got writes=%0d pend=%h expected 0/0", obs_wr - obs_rd, pend); obs_rd = obs_wr; end
   endtask

   task test_reassert();
      logic [95:0] e, o;
      cfg(2'd1, 64'h2_0000_0003, 32'hBEEF0001, 1'b0);
      wr_ready = 1'b0;
      intr_req = 4'b0010;
      exp_q.push_back({64'h2_0000_0003, 32'hBEEF0001});
      tick();
      intr_req = 4'h0;
      tick();
      @(negedge clk);
      n_cmp++; if (wr_valid !== 1'b1) begin n_err++; $display("FAIL reassert valid: got %b expected 1", wr_valid); end
      tick();
      wr_ready = 1'b1;
      intr_req = 4'b0010;
      exp_q.push_back({64'h2_0000_0003, 32'hBEEF0001});
      tick();
      intr_req = 4'h0;
      @(negedge clk);
      n_cmp++; if (pend !== 4'b0010) begin n_err++; $display("FAIL reassert pend: got %h expected 2", pend); end
      run(5);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_cmp++;
         o = (obs_rd < obs_wr) ? obs_ad[obs_rd] : 'x;
         if (obs_rd < obs_wr) obs_rd++;
         if (o !== e) begin n_err++; $display("FAIL reassert write: got %h expected %h", o, e); end
      end
      n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL reassert extra writes: got %0d expected 0", obs_wr - obs_rd); obs_rd = obs_wr; end
      n_cmp++; if (sent_cnt !== 3'd2 || pend !== 4'h0) begin n_err++; $display("FAIL reassert end: got cnt=%0d pend=%h expected 2/0", sent_cnt, pend); end
   endtask

   task test_saturate();
      logic [95:0] e, o;
      do_reset();
      cfg(2'd0, 64'h40, 32'h5A5A0000, 1'b0);
      func_en = 1'b1;
      wr_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         intr_req = 4'b0001;
         exp_q.push_back({64'h40, 32'h5A5A0000});
         tick();
         intr_req = 4'h0;
         run(2);
         if (i == 6) begin
            @(negedge clk);
            n_cmp++; if (sent_cnt !== 3'd7) begin n_err++; $display("FAIL saturate at 7: got %0d expected 7", sent_cnt); end
         end
      end
      run(3);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_cmp++;
         o = (obs_rd < obs_wr) ? obs_ad[obs_rd] : 'x;
         if (obs_rd < obs_wr) obs_rd++;
         if (o !== e) begin n_err++; $display("FAIL saturate write: got %h expected %h", o, e); end
      end
      n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL saturate extra writes: got %0d expected 0", obs_wr - obs_rd); obs_rd = obs_wr; end
      n_cmp++; if (sent_cnt !== 3'd7) begin n_err++; $display("FAIL saturate hold: got %0d expected 7", sent_cnt); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_stall();
      test_all4();
      test_mask();
      test_rst_issue();
      test_reassert();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end
endmodule

// File: doc/msix_wr_gen.md
MSIX_WR_GEN -- requirements
Module: msix_wr_gen

Interface
REQ-001 SHALL have parameter NUM_VEC, default 4, number of MSI-X vectors (2..16).
REQ-002 SHALL have parameter SENT_W, default 16, width of the sent-message counter.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cfg_we  input  1  table write strobe, one-cycle.
REQ-006 SHALL have port cfg_vec  input  $clog2(NUM_VEC)  table entry index.
REQ-007 SHALL have port cfg_addr  input  64  message address for the entry.
REQ-008 SHALL have port cfg_data  input  32  message data DW for the entry.
REQ-009 SHALL have port cfg_mask  input  1  per-vector mask bit for the entry.
REQ-010 SHALL have port func_en  input  1  global MSI-X enable; 0 blocks issue.
REQ-011 SHALL have port intr_req  input  NUM_VEC  per-vector interrupt event pulses.
REQ-012 SHALL have port wr_valid  output  1  DW host write request valid.
REQ-013 SHALL have port wr_ready  input  1  host write port accepts the request.
REQ-014 SHALL have port wr_addr  output  64  host write address.
REQ-015 SHALL have port wr_data  output  32  host write data DW.
REQ-016 SHALL have port pend  output  NUM_VEC  pending-bit array.
REQ-017 SHALL have port sent_cnt  output  SENT_W  count of accepted messages.

Function
REQ-018 SHALL hold per vector: addr (64), data (32) and mask (1), written on cfg_we for index cfg_vec; an out-of-range cfg_vec SHALL be ignored.
REQ-019 SHALL set pend[i] the cycle after intr_req[i]=1; repeated requests while pend[i]=1 SHALL coalesce into one message.
REQ-020 SHALL implement FSM IDLE, ISSUE.
REQ-021 IDLE: if func_en=1 and (pend & ~mask) != 0, SHALL select one eligible vector round-robin, starting from the vector after the last one accepted (vector 0 after reset), latch its addr/data into wr_addr/wr_data, set wr_valid=1 and go to ISSUE.
REQ-022 ISSUE: wr_valid, wr_addr and wr_data SHALL stay stable until wr_valid&wr_ready; then wr_valid=0, pend[sel] cleared, sent_cnt incremented, FSM back to IDLE.
REQ-023 Latency: from idle with an unmasked vector and func_en=1, intr_req at cycle N SHALL give wr_valid=1 at cycle N+2; with wr_ready held high, back-to-back messages SHALL issue every 2 cycles.
REQ-024 intr_req[sel] in the same cycle as the accepting handshake SHALL leave pend[sel]=1, which then gives a new message.
REQ-025 A masked pending vector SHALL keep pend set; clearing its mask SHALL make it eligible in the next IDLE cycle.
REQ-026 A cfg_we, mask set or func_en deassertion during ISSUE SHALL NOT alter or withdraw the in-flight request.
REQ-027 sent_cnt SHALL saturate at all-ones.
REQ-028 wr_addr SHALL be passed unmodified (no alignment forced).

Reset
REQ-029 On rst=1 at a clock edge: FSM=IDLE, wr_valid=0, wr_addr=0, wr_data=0, pend=0, sent_cnt=0, all table addr/data=0, all mask=1, round-robin pointer=0.
REQ-030 rst during ISSUE SHALL drop wr_valid the next cycle with no handshake counted; rst SHALL override cfg_we and intr_req in the same cycle.

Verification
REQ-031 Program vec0 addr=0x1 data=0x12345678 mask=0, func_en=1, pulse intr_req[0] at cycle N -> wr_valid at N+2 with wr_addr=0x1, wr_data=0x12345678; host flags the MSI-X; sent_cnt=1.
REQ-032 wr_ready held 0 for 5 cycles, cfg_we rewrites vec0 data=0xDEAD -> wr_data stays 0x12345678 until accepted; the next message carries 0xDEAD.
REQ-033 intr_req=4'b1111 with all unmasked, wr_ready=1 -> writes in order vec0,1,2,3 at 2-cycle spacing; pend=0 and sent_cnt=4 at the end.
REQ-034 vec2 masked, intr_req[2] pulsed 3 times -> no write, pend[2]=1; unmask -> exactly one write with vec2 data.
REQ-035 rst asserted while wr_valid=1 -> wr_valid=0, pend=0 and sent_cnt=0 next cycle; no write reaches host memory.
REQ-036 intr_req[1] in the same cycle as vec1 handshake -> a second vec1 write follows; sent_cnt=2.
